and_gate: RTL and testbench

AND_GATE -- requirements
Module: and_gate

---
 rtl/and_gate_pkg.sv | 25 ++
 rtl/and_gate_if.sv | 32 +++
 rtl/and_gate_sat_counter.sv | 27 ++
 rtl/and_gate.sv | 52 +++++
 tb/tb_and_gate.sv | 143 ++++++++++++++
 5 files changed

// File: rtl/and_gate_pkg.sv
// and_gate_pkg: input-pair encoding shared by the AND gate and its bench.
// Revision 1.0
`default_nettype none

package and_gate_pkg;

   localparam int NUM_PAIRS = 4;

   typedef enum logic [1:0] {
      PAIR_00 = 2'b00,
      PAIR_01 = 2'b01,
      PAIR_10 = 2'b10,
      PAIR_11 = 2'b11
   } pair_e;

   // One-hot select of the counter addressed by {a[0],b[0]}.
   function automatic logic [NUM_PAIRS-1:0] pair_onehot(input logic a0, input logic b0);
      pair_e p;
      p = pair_e'({a0, b0});
      return NUM_PAIRS'(1) << p;
   endfunction

endpackage

`default_nettype wire

// File: rtl/and_gate_if.sv
// and_gate_if: operand/enable inputs and result/counter outputs of and_gate.
// Revision 1.0
`default_nettype none

interface and_gate_if #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
);
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             en;
   logic             clr;
   logic [WIDTH-1:0] y;
   logic             y_all;
   logic [WIDTH-1:0] y_q;
   logic [CNT_W-1:0] cnt_00;
   logic [CNT_W-1:0] cnt_01;
   logic [CNT_W-1:0] cnt_10;
   logic [CNT_W-1:0] cnt_11;

   modport master (
      output a, b, en, clr,
      input  y, y_all, y_q, cnt_00, cnt_01, cnt_10, cnt_11
   );

   modport slave (
      input  a, b, en, clr,
      output y, y_all, y_q, cnt_00, cnt_01, cnt_10, cnt_11
   );
endinterface

`default_nettype wire

// File: rtl/and_gate_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; clr outranks inc, rst outranks both.
// Revision 1.0
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 8
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             clr,
   input  wire logic             inc,
   output logic [CNT_W-1:0]      count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/and_gate.sv
// and_gate: combinational AND with registered copy and per-input-pair saturating counters.
// Revision 1.0
`default_nettype none

module and_gate
   import and_gate_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  wire logic  clk,
   input  wire logic  rst,
   and_gate_if.slave  bus
);

   logic [WIDTH-1:0]     y_held;
   logic [NUM_PAIRS-1:0] pair_hit;
   logic [CNT_W-1:0]     counts [NUM_PAIRS];

   assign bus.y     = bus.a & bus.b;
   assign bus.y_all = &bus.y;
   assign bus.y_q   = y_held;

   always_ff @(posedge clk) begin
      if (rst) begin
         y_held <= '0;
      end else if (bus.en) begin
         y_held <= bus.a & bus.b;
      end
   end

   // Only bit 0 of each operand chooses which counter advances.
   assign pair_hit = pair_onehot(bus.a[0], bus.b[0]);

   for (genvar i = 0; i < NUM_PAIRS; i++) begin : g_counters
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst   (rst),
         .clr   (bus.clr),
         .inc   (bus.en & pair_hit[i]),
         .count (counts[i])
      );
   end

   assign bus.cnt_00 = counts[PAIR_00];
   assign bus.cnt_01 = counts[PAIR_01];
   assign bus.cnt_10 = counts[PAIR_10];
   assign bus.cnt_11 = counts[PAIR_11];

endmodule

`default_nettype wire

// File: tb/tb_and_gate.sv
// tb_and_gate: directed checks of and_gate in three parameterisations.
// Revision 1.0
`default_nettype none

module tb_and_gate;

   logic clk = 1'b0;
   logic rst1 = 1'b0;
   logic rst2 = 1'b0;
   logic rst3 = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   and_gate_if #(.WIDTH(1), .CNT_W(8)) bus1 ();
   and_gate_if #(.WIDTH(1), .CNT_W(2)) bus2 ();
   and_gate_if #(.WIDTH(4), .CNT_W(8)) bus3 ();

   and_gate #(.WIDTH(1), .CNT_W(8)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));
   and_gate #(.WIDTH(1), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2.slave));
   and_gate #(.WIDTH(4), .CNT_W(8)) u_dut3 (.clk(clk), .rst(rst3), .bus(bus3.slave));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnt1(input string tag, input int c00, input int c01, input int c10, input int c11);
      check({tag, " cnt_00"}, 32'(bus1.cnt_00), 32'(c00));
      check({tag, " cnt_01"}, 32'(bus1.cnt_01), 32'(c01));
      check({tag, " cnt_10"}, 32'(bus1.cnt_10), 32'(c10));
      check({tag, " cnt_11"}, 32'(bus1.cnt_11), 32'(c11));
   endtask

   initial begin
      logic [1:0] ab_vec [4];
      logic       y_exp  [4];
      ab_vec = '{2'b00, 2'b01, 2'b10, 2'b11};
      y_exp  = '{1'b0, 1'b0, 1'b0, 1'b1};

      bus1.a = '0; bus1.b = '0; bus1.en = 1'b0; bus1.clr = 1'b0;
      bus2.a = '0; bus2.b = '0; bus2.en = 1'b0; bus2.clr = 1'b0;
      bus3.a = '0; bus3.b = '0; bus3.en = 1'b0; bus3.clr = 1'b0;

      // Truth table, purely combinational, no clock edge involved.
      for (int i = 0; i < 4; i++) begin
         bus1.a = ab_vec[i][1];
         bus1.b = ab_vec[i][0];
         #2;
         check($sformatf("tt y ab=%02b", ab_vec[i]), 32'(bus1.y), 32'(y_exp[i]));
         check($sformatf("tt y_all ab=%02b", ab_vec[i]), 32'(bus1.y_all), 32'(y_exp[i]));
         #3;
      end

      // Reset all three instances.
      @(posedge clk); #1;
      rst1 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;
      tick();
      rst1 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
      check("reset y_q", 32'(bus1.y_q), 32'h0);
      check_cnt1("reset", 0, 0, 0, 0);
      check("reset2 cnt_11", 32'(bus2.cnt_11), 32'h0);

      // One cycle of each input pair; y_q follows y one cycle later.
      bus1.en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus1.a = ab_vec[i][1];
         bus1.b = ab_vec[i][0];
         tick();
         check($sformatf("lag y_q ab=%02b", ab_vec[i]), 32'(bus1.y_q), 32'(y_exp[i]));
      end
      bus1.en = 1'b0;
      check_cnt1("one each", 1, 1, 1, 1);

      // en=0 holds y_q and counters.
      bus1.a = 1'b0; bus1.b = 1'b0;
      tick();
      check("hold y_q", 32'(bus1.y_q), 32'h1);
      check_cnt1("hold", 1, 1, 1, 1);

      // clr beats en; y_q still loads.
      bus1.a = 1'b1; bus1.b = 1'b1; bus1.en = 1'b1; bus1.clr = 1'b1;
      tick();
      bus1.clr = 1'b0;
      check("clr y_q", 32'(bus1.y_q), 32'h1);
      check_cnt1("clr", 0, 0, 0, 0);

      // Build up counts, then reset beats en.
      tick();
      check("pre-rst cnt_11", 32'(bus1.cnt_11), 32'h1);
      check("pre-rst y_q", 32'(bus1.y_q), 32'h1);
      rst1 = 1'b1;
      tick();
      check("rst y_q", 32'(bus1.y_q), 32'h0);
      check_cnt1("rst", 0, 0, 0, 0);
      check("rst y", 32'(bus1.y), 32'h1);
      check("rst y_all", 32'(bus1.y_all), 32'h1);
      rst1 = 1'b0;
      bus1.en = 1'b0;

      // CNT_W=2 saturates at 3.
      bus2.a = 1'b1; bus2.b = 1'b1; bus2.en = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check($sformatf("sat cnt_11 cyc%0d", i), 32'(bus2.cnt_11), 32'((i > 3) ? 3 : i));
      end
      bus2.en = 1'b0;
      check("sat cnt_00", 32'(bus2.cnt_00), 32'h0);
      check("sat cnt_01", 32'(bus2.cnt_01), 32'h0);
      check("sat cnt_10", 32'(bus2.cnt_10), 32'h0);

      // WIDTH=4 combinational and registered paths.
      bus3.a = 4'b1011; bus3.b = 4'b1110;
      #1;
      check("w4 y", 32'(bus3.y), 32'hA);
      check("w4 y_all", 32'(bus3.y_all), 32'h0);
      bus3.a = 4'hF; bus3.b = 4'hF;
      #1;
      check("w4 y ff", 32'(bus3.y), 32'hF);
      check("w4 y_all ff", 32'(bus3.y_all), 32'h1);
      bus3.a = 4'b0110; bus3.b = 4'b0111; bus3.en = 1'b1;
      tick();
      bus3.en = 1'b0;
      check("w4 y_q", 32'(bus3.y_q), 32'h6);
      check("w4 cnt_01", 32'(bus3.cnt_01), 32'h1);
      check("w4 cnt_11", 32'(bus3.cnt_11), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
